tiled_systolic_matmul: RTL

Computes C = A·B (+ C_prev) for M×M signed matrices, where M = NT·TILE, using an NT×NT grid of TILE×TILE systolic tile engines.
- Runs NT K-phases. In phase k, tile (i,j) receives A block (i,k) and B block (k,j).
- Accumulates tile results on-chip, with optional saturation.
- Returns the result over a valid/ready output handshake.
- Sits between the operand buffer and the NPU result writeback.

---
 rtl/tiled_systolic_matmul.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tiled_systolic_matmul.sv
// Tiled systolic matrix multiplier: an NT x NT grid of output-stationary TILE x TILE engines is
// swept over NT K-phases, accumulating C = A*B (+ C_prev) with wrap or saturate on output.
module tiled_systolic_matmul #(
  parameter int unsigned TILE       = 8,
  parameter int unsigned NT         = 2,
  parameter int unsigned IN_W       = 8,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter int          STALL_TILE = -1  // tile index (i*NT+j) whose valid is suppressed
) (
  input  logic                                i_clk,
  input  logic                                i_arst,
  input  logic                                i_validInput,
  output logic                                o_readyInput,
  input  logic [NT*TILE*NT*TILE*IN_W-1:0]     i_a,
  input  logic [NT*TILE*NT*TILE*IN_W-1:0]     i_b,
  input  logic                                i_accumMode,
  input  logic                                i_satEn,
  output logic [NT*TILE*NT*TILE*ACC_W-1:0]    o_c,
  output logic                                o_validResult,
  input  logic                                i_readyResult,
  output logic                                o_busy,
  output logic                                o_overflow,
  output logic                                o_timeout
);
  localparam int unsigned M  = NT * TILE;
  localparam int unsigned MM = M * M;
  localparam int unsigned AW = ACC_W + $clog2(NT) + 2;
  localparam int unsigned PW = 2 * IN_W + $clog2(TILE);
  localparam int unsigned KW = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned CW = $clog2(3 * TILE);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [ACC_W-1:0] SatMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SatMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StOut} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [WW-1:0]            wd_q, wd_d;
  logic [MM*IN_W-1:0]       a_q, b_q;
  logic                     accum_q, sat_q;
  logic [MM*ACC_W-1:0]      c_q, c_red;
  logic                     valid_q, valid_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic                     capture, acc_load, out_load, launch;
  logic signed [AW-1:0]     acc_q [MM];
  logic signed [AW-1:0]     sum_d [MM];
  logic signed [PW-1:0]     tile_res [MM];
  logic [NT*NT-1:0]         tile_vld;

  assign launch = (state_q == StLaunch);

  for (genvar ti = 0; ti < NT; ti++) begin : g_ti
    for (genvar tj = 0; tj < NT; tj++) begin : g_tj
      localparam bit Stalled = (int'(ti * NT + tj) == STALL_TILE);
      logic                   run_q, done_q;
      logic [CW-1:0]          cnt_q;
      logic signed [IN_W-1:0] edge_a [TILE];
      logic signed [IN_W-1:0] edge_b [TILE];
      logic signed [IN_W-1:0] pe_a [TILE][TILE];
      logic signed [IN_W-1:0] pe_b [TILE][TILE];

      // Skewed feed: row r / column r sees operand index kk = step - r.
      always_comb begin
        for (int r = 0; r < TILE; r++) begin
          edge_a[r] = '0;
          edge_b[r] = '0;
          if (int'(cnt_q) >= r && int'(cnt_q) < r + TILE) begin
            edge_a[r] = a_q[((ti*TILE + r)*M + int'(k_q)*TILE + int'(cnt_q) - r)*IN_W +: IN_W];
            edge_b[r] = b_q[((int'(k_q)*TILE + int'(cnt_q) - r)*M + tj*TILE + r)*IN_W +: IN_W];
          end
        end
      end

      always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
          run_q  <= 1'b0;
          done_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          done_q <= 1'b0;
          if (launch) begin
            run_q <= 1'b1;
            cnt_q <= '0;
          end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(3 * TILE - 3)) begin
              run_q  <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
      end

      assign tile_vld[ti*NT + tj] = done_q & ~Stalled;

      for (genvar r = 0; r < TILE; r++) begin : g_row
        for (genvar c = 0; c < TILE; c++) begin : g_col
          logic signed [IN_W-1:0]   a_in, b_in, pa_q, pb_q;
          logic signed [2*IN_W-1:0] prod;
          logic signed [PW-1:0]     pacc_q;

          if (c == 0) begin : g_a_edge
            assign a_in = edge_a[r];
          end else begin : g_a_pass
            assign a_in = pe_a[r][c-1];
          end
          if (r == 0) begin : g_b_edge
            assign b_in = edge_b[c];
          end else begin : g_b_pass
            assign b_in = pe_b[r-1][c];
          end

          assign prod = a_in * b_in;

          always_ff @(posedge i_clk or posedge i_arst) begin
            if (i_arst) begin
              pa_q   <= '0;
              pb_q   <= '0;
              pacc_q <= '0;
            end else if (launch) begin
              pa_q   <= '0;
              pb_q   <= '0;
              pacc_q <= '0;
            end else if (run_q) begin
              pa_q   <= a_in;
              pb_q   <= b_in;
              pacc_q <= pacc_q + PW'(prod);
            end
          end

          assign pe_a[r][c] = pa_q;
          assign pe_b[r][c] = pb_q;
          assign tile_res[(ti*TILE + r)*M + tj*TILE + c] = pacc_q;
        end
      end
    end
  end

  // Accumulate tile outputs and reduce each element to ACC_W for the final phase.
  always_comb begin
    ovf_d = 1'b0;
    c_red = '0;
    for (int e = 0; e < MM; e++) begin
      if (k_q != '0) begin
        sum_d[e] = acc_q[e];
      end else if (accum_q) begin
        sum_d[e] = AW'($signed(c_q[e*ACC_W +: ACC_W]));
      end else begin
        sum_d[e] = '0;
      end
      sum_d[e] = sum_d[e] + AW'(tile_res[e]);
      c_red[e*ACC_W +: ACC_W] = sum_d[e][ACC_W-1:0];
      if (!(&sum_d[e][AW-1:ACC_W-1]) && (|sum_d[e][AW-1:ACC_W-1])) begin
        ovf_d = 1'b1;
        if (sat_q) begin
          c_red[e*ACC_W +: ACC_W] = sum_d[e][AW-1] ? SatMin : SatMax;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wd_d     = wd_q;
    valid_d  = valid_q;
    tmo_d    = tmo_q;
    capture  = 1'b0;
    acc_load = 1'b0;
    out_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_validInput) begin
          capture = 1'b1;
          k_d     = '0;
          tmo_d   = 1'b0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        // The launch cycle counts toward the budget, so the abort lands TIMEOUT cycles later.
        wd_d    = WW'(1);
        state_d = StWait;
      end
      StWait: begin
        wd_d = wd_q + 1'b1;
        if (&tile_vld) begin
          acc_load = 1'b1;
          if (k_q == KW'(NT - 1)) begin
            out_load = 1'b1;
            valid_d  = 1'b1;
            state_d  = StOut;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = StLaunch;
          end
        end else if (wd_d == WW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StOut: begin
        if (i_readyResult) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= StIdle;
      k_q     <= '0;
      wd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      accum_q <= 1'b0;
      sat_q   <= 1'b0;
      c_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      for (int e = 0; e < MM; e++) acc_q[e] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      if (capture) begin
        a_q     <= i_a;
        b_q     <= i_b;
        accum_q <= i_accumMode;
        sat_q   <= i_satEn;
      end
      if (acc_load) begin
        for (int e = 0; e < MM; e++) acc_q[e] <= sum_d[e];
      end
      if (out_load) begin
        c_q   <= c_red;
        ovf_q <= ovf_d;
      end
    end
  end

  assign o_readyInput  = (state_q == StIdle);
  assign o_busy        = (state_q != StIdle);
  assign o_c           = c_q;
  assign o_validResult = valid_q;
  assign o_overflow    = ovf_q;
  assign o_timeout     = tmo_q;

endmodule
